// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: operand, pass-through and shared ALU signals between pipeline and multiply sequencer.
interface mul_sequencer_if #(parameter int WIDTH = 64) ();
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       pipe_ctrl;
  logic [WIDTH-1:0] pipe_a;
  logic [WIDTH-1:0] pipe_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  modport slave (
    input  start, op_a, op_b, pipe_ctrl, pipe_a, pipe_b, alu_result,
    output alu_a, alu_b, alu_ctrl, stall, busy, done, product
  );
  modport master (
    output start, op_a, op_b, pipe_ctrl, pipe_a, pipe_b, alu_result,
    input  alu_a, alu_b, alu_ctrl, stall, busy, done, product
  );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-and-add multiply that borrows the shared ALU; MUL_EARLY_EXIT_EN stops once the multiplier runs out of set bits.
module mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input logic           clk,
  input logic           reset,
  mul_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0] acc_nx;
  logic             last;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
  // acc_nx is the value acc takes this edge, so the product latches the final sum directly
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    acc_nx    = mplier_q[0] ? bus.alu_result : acc_q;
`ifdef MUL_EARLY_EXIT_EN
    last      = mplier_q[WIDTH-1:1] == '0;
`else
    last      = cnt_q == CNT_W'(WIDTH - 1);
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        mcand_d  = bus.op_a;
        mplier_d = bus.op_b;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = BUSY;
      end
      BUSY: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last) begin
          state_d   = DONE;
          product_d = acc_nx;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy     = state_q == BUSY;
  assign bus.done     = state_q == DONE;
  assign bus.stall    = bus.busy | bus.done | (state_q == IDLE & bus.start);
  assign bus.alu_a    = bus.busy ? acc_q : bus.pipe_a;
  assign bus.alu_b    = bus.busy ? mcand_q : bus.pipe_b;
  assign bus.alu_ctrl = bus.busy ? 3'b010 : bus.pipe_ctrl;
  assign bus.product  = product_q;
endmodule
